// File: rtl/fp16_pkg.sv
// fp16_pkg: shared types and constants for the half-precision add engine.
// States, field widths, default memory map and the packed fp16 word layout.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = 11;

  localparam logic [7:0] DEF_OP_A_ADDR = 8'd8;
  localparam logic [7:0] DEF_OP_B_ADDR = 8'd10;
  localparam logic [7:0] DEF_RES_ADDR  = 8'd12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A_LO,
    S_RD_A_HI,
    S_RD_B_LO,
    S_RD_B_HI,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp16_unpack.sv
// fp16_unpack: splits a half-precision word into sign, exponent and
// 11-bit mantissa with the hidden bit restored for normal numbers.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]       i_word,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant
);

  fp16_t w_f;

  assign w_f    = i_word;
  assign o_sign = w_f.sign;
  assign o_exp  = w_f.exp;
  assign o_mant = {|w_f.exp, w_f.frac};

endmodule

// File: rtl/fp16_add_engine.sv
// fp16_add_engine: reads two fp16 operands from byte memory, adds them
// with truncation, writes the 16-bit result back and raises done.
module fp16_add_engine
  import fp16_pkg::*;
#(
  parameter logic [7:0] OP_A_ADDR = DEF_OP_A_ADDR,
  parameter logic [7:0] OP_B_ADDR = DEF_OP_B_ADDR,
  parameter logic [7:0] RES_ADDR  = DEF_RES_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  state_t r_state, w_next;

  logic [15:0]       r_a;
  logic [7:0]        r_b_lo;
  logic              r_sign, r_sub, r_zero, r_done;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_ml, r_ms;
  logic [3:0]        r_cnt;

  logic [15:0]       w_b;
  logic              w_sa, w_sb, w_a_big, w_shift;
  logic [EXP_W-1:0]  w_ea, w_eb, w_d, w_eeff;
  logic [MANT_W-1:0] w_ma, w_mb, w_diff;
  logic [MANT_W:0]   w_sum;
  logic [3:0]        w_cnt;
  fp16_t             w_res;

  assign w_b = {mem_rd_data, r_b_lo};

  fp16_unpack u_unp_a (
    .i_word (r_a),
    .o_sign (w_sa),
    .o_exp  (w_ea),
    .o_mant (w_ma)
  );

  fp16_unpack u_unp_b (
    .i_word (w_b),
    .o_sign (w_sb),
    .o_exp  (w_eb),
    .o_mant (w_mb)
  );

  assign w_a_big = r_a[14:0] >= w_b[14:0];
  assign w_d     = w_a_big ? w_ea - w_eb : w_eb - w_ea;
  assign w_cnt   = (w_d > 5'd12) ? 4'd12 : w_d[3:0];

  // exponent 0 behaves as 1 while the hidden bit is clear
  assign w_eeff  = (r_exp == '0) ? 5'd1 : r_exp;
  assign w_sum   = {1'b0, r_ml} + {1'b0, r_ms};
  assign w_diff  = r_ml - r_ms;
  assign w_shift = !r_zero && !r_ml[10] && (r_exp > 5'd1);

  always_comb begin
    w_res = '0;
    if (!r_zero) begin
      w_res.sign = r_sign;
      w_res.exp  = r_ml[10] ? r_exp : '0;
      w_res.frac = r_ml[9:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE) && !start;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE:    if (start) w_next = S_RD_A_LO;
      S_RD_A_LO: w_next = S_RD_A_HI;
      S_RD_A_HI: w_next = S_RD_B_LO;
      S_RD_B_LO: w_next = S_RD_B_HI;
      S_RD_B_HI: w_next = S_ALIGN;
      S_ALIGN:   if (r_cnt == '0) w_next = S_ADD;
      S_ADD:     w_next = S_NORM;
      S_NORM:    if (!w_shift) w_next = S_WR_LO;
      S_WR_LO:   w_next = S_WR_HI;
      S_WR_HI:   w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= '0;
      r_b_lo <= '0;
      r_sign <= 1'b0;
      r_sub  <= 1'b0;
      r_zero <= 1'b0;
      r_exp  <= '0;
      r_ml   <= '0;
      r_ms   <= '0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_RD_A_LO: r_a[7:0]  <= mem_rd_data;
        S_RD_A_HI: r_a[15:8] <= mem_rd_data;
        S_RD_B_LO: r_b_lo    <= mem_rd_data;
        S_RD_B_HI: begin
          r_sub  <= w_sa ^ w_sb;
          r_sign <= w_a_big ? w_sa : w_sb;
          r_exp  <= w_a_big ? w_ea : w_eb;
          r_ml   <= w_a_big ? w_ma : w_mb;
          r_ms   <= w_a_big ? w_mb : w_ma;
          r_cnt  <= w_cnt;
          r_zero <= 1'b0;
        end
        S_ALIGN: begin
          if (r_cnt != '0) begin
            r_ms  <= r_ms >> 1;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ADD: begin
          if (r_sub) begin
            r_ml   <= w_diff;
            r_exp  <= w_eeff;
            r_zero <= (w_diff == '0);
          end else if (w_sum[11]) begin
            if (w_eeff >= 5'd30) begin
              r_exp <= 5'd31;
              r_ml  <= 11'h400;
            end else begin
              r_exp <= w_eeff + 5'd1;
              r_ml  <= w_sum[11:1];
            end
          end else begin
            r_exp <= w_eeff;
            r_ml  <= w_sum[10:0];
          end
        end
        S_NORM: begin
          if (w_shift) begin
            r_ml  <= r_ml << 1;
            r_exp <= r_exp - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    unique case (r_state)
      S_RD_A_LO: mem_addr = OP_A_ADDR;
      S_RD_A_HI: mem_addr = OP_A_ADDR + 8'd1;
      S_RD_B_LO: mem_addr = OP_B_ADDR;
      S_RD_B_HI: mem_addr = OP_B_ADDR + 8'd1;
      S_WR_LO: begin
        mem_addr    = RES_ADDR;
        mem_wr_en   = 1'b1;
        mem_wr_data = w_res[7:0];
      end
      S_WR_HI: begin
        mem_addr    = RES_ADDR + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = w_res[15:8];
      end
      default: ;
    endcase
  end

  assign done = r_done;

endmodule

// File: tb/tb_fp16_add_engine.sv
// tb_fp16_add_engine: directed vector table plus hand sequences for
// mid-operation start pulses and mid-operation reset.
module tb_fp16_add_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [7:0]  res_lo = '0;
  logic [7:0]  res_hi = '0;
  int          wr_total = 0;
  int          bad_wr = 0;

  int n_cmp = 0;
  int n_err = 0;

  fp16_add_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rd_data = 8'h00;
    case (mem_addr)
      8'd8:    mem_rd_data = op_a[7:0];
      8'd9:    mem_rd_data = op_a[15:8];
      8'd10:   mem_rd_data = op_b[7:0];
      8'd11:   mem_rd_data = op_b[15:8];
      default: mem_rd_data = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_total <= wr_total + 1;
      if (mem_addr == 8'd12)      res_lo <= mem_wr_data;
      else if (mem_addr == 8'd13) res_hi <= mem_wr_data;
      else                        bad_wr <= bad_wr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int pulse_at, input logic [15:0] exp_res,
                        input int exp_lat);
    int w0;
    int lat;
    op_a = a;
    op_b = b;
    w0 = wr_total;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_fall", 32'(done), 32'd0);
    lat = 0;
    while (lat < 60 && !done) begin
      @(posedge clk);
      lat++;
      #1;
      start = (lat == pulse_at);
    end
    start = 1'b0;
    if (!done) $display("FAIL timeout: done never rose for %h+%h", a, b);
    check($sformatf("res %h+%h", a, b), 32'({res_hi, res_lo}),
          32'(exp_res));
    check($sformatf("lat %h+%h", a, b), 32'(lat), 32'(exp_lat));
    check($sformatf("wrs %h+%h", a, b), 32'(wr_total - w0), 32'd2);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int w0;
    vecs[0] = '{16'h1A04, 16'h1A04, 16'h1E04, 10};
    vecs[1] = '{16'h4204, 16'h4204, 16'h4604, 10};
    vecs[2] = '{16'h4000, 16'h3C00, 16'h4200, 11};
    vecs[3] = '{16'h3C00, 16'h4000, 16'h4200, 11};
    vecs[4] = '{16'h4200, 16'hC000, 16'h3C00, 11};
    vecs[5] = '{16'hC000, 16'h4200, 16'h3C00, 11};
    vecs[6] = '{16'h4200, 16'hC200, 16'h0000, 10};
    vecs[7] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 10};
    vecs[8] = '{16'h5000, 16'h0400, 16'h5000, 22};

    #1;
    check("rst done", 32'(done), 32'd0);
    check("rst wr_en", 32'(mem_wr_en), 32'd0);
    check("rst addr", 32'(mem_addr), 32'd0);
    check("rst wr_data", 32'(mem_wr_data), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, 0, vecs[i].res, vecs[i].lat);

    run_op(16'h5000, 16'h0400, 7, 16'h5000, 22);
    check("bad_wr", 32'(bad_wr), 32'd0);

    op_a = 16'h5000;
    op_b = 16'h0400;
    w0 = wr_total;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort done", 32'(done), 32'd0);
    check("abort wr_en", 32'(mem_wr_en), 32'd0);
    check("abort addr", 32'(mem_addr), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort writes", 32'(wr_total - w0), 32'd0);
    check("abort idle done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(16'h4000, 16'h3C00, 0, 16'h4200, 11);
    check("bad_wr end", 32'(bad_wr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp16_add_engine.md
# fp16_add_engine

Hardware responder for the program-3 float-addition handshake. On a `start` pulse it reads two IEEE-754 half-precision operands from byte-wide data memory and adds them with truncation, no rounding. It writes the 16-bit result back to memory and raises `done` until the next request. It is the golden hardware model that the float-add bench compares a student processor against.

## Interface
- `OP_A_ADDR`, default 8: byte address of operand A low byte; high byte is at +1.
- `OP_B_ADDR`, default 10: byte address of operand B low byte; high byte is at +1.
- `RES_ADDR`, default 12: byte address of result low byte; high byte is at +1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `done`  out  1  high from completion until the next accepted `start` or reset.
- `mem_addr`  out  8  data-memory byte address.
- `mem_rd_data`  in  8  data-memory read data, combinational from `mem_addr`.
- `mem_wr_en`  out  1  data-memory write strobe.
- `mem_wr_data`  out  8  data-memory write data.

## Operation
- State sequence: IDLE → RD_A_LO → RD_A_HI → RD_B_LO → RD_B_HI → ALIGN → ADD → NORM → WR_LO → WR_HI → DONE.
- DONE returns to RD_A_LO on `start`; IDLE and DONE ignore no other input.
- Unpack each operand: sign = bit 15, exp = bits 14:10, mant = {|exp, bits 9:0} (11 bits).
- In RD_B_HI, order operands by magnitude {exp, frac}: L is the larger, S the smaller.
- Set d = expL − expS, saturated to 12.
- ALIGN shifts S right by one bit per cycle, truncating shifted-out bits. It exits when the counter reaches 0, so it takes d+1 cycles.
- ADD, signs equal: 12-bit sum = mL + mS.
  - On carry-out, shift right 1 and increment exp.
  - If exp reaches 31, the result is infinity: exp 31, frac 0.
- ADD, signs differ: difference = mL − mS.
  - A zero difference gives result 0x0000 (+0) and skips NORM shifts.
- NORM shifts left by one bit and decrements exp per cycle while bit 10 = 0 and exp > 1.
  - If exp = 1 and bit 10 is still 0, the result is subnormal (exp 0).
  - NORM takes n+1 cycles.
- Result sign = sign of L; +0 is forced on exact cancellation.
- Infinity and NaN inputs need no special handling. An exp of 31 simply saturates.
- WR_LO writes result[7:0] to RES_ADDR. WR_HI writes result[15:8] to RES_ADDR+1.
- Operand memory is never written.

## Timing
- Reset (reset = 0) forces, asynchronously: state IDLE, `done` 0, `mem_wr_en` 0, `mem_addr` 0, `mem_wr_data` 0.
- Reset mid-operation aborts without a write. No partial result may reach memory after reset is asserted.
- `start` is accepted on the rising edge in IDLE or DONE. `done` falls on that same edge.
- `start` during any busy state is ignored: no restart and no queuing.
- Each RD state drives `mem_addr` and captures `mem_rd_data` on the exiting edge.
- `mem_wr_en` is high for exactly the two WR cycles.
- `done` rises on edge 10+d+n after the accepting edge. `done` is registered; no combinational path from `start`.
- `start` held high in DONE re-launches every completion; the bench pulses `start` for one cycle.

## Structure
- Package `fp16_pkg` holds:
  - the state enum;
  - the EXP_W=5, FRAC_W=10 and MANT_W=11 constants;
  - the default address constants;
  - an `fp16_t` packed struct {sign, exp, frac}.
- Sub-module `fp16_unpack`: combinational, 16-bit word → sign, exp, 11-bit mant with hidden bit. It is instantiated twice.

## Test plan
- A = 0x1A04, B = 0x1A04 → mem[13:12] = 0x1E04; `done` on edge 10 after `start`.
- A = 0x4204, B = 0x4204 → 0x4604. A = 0x4000, B = 0x3C00 (2+1) → 0x4200; `done` on edge 11 (d = 1).
- A = 0x4200, B = 0xC000 (3 − 2) → 0x3C00, n = 1. A = 0x4200, B = 0xC200 → 0x0000.
- A = 0x7BFF, B = 0x7BFF → 0x7C00 (saturate to infinity). A = 0x5000, B = 0x0400 → 0x5000 (d capped at 12, S truncated to 0).
- Pulse `start` again mid-ALIGN → ignored; result and latency are unchanged.
- Drive reset low mid-ALIGN → `done` 0 and no `mem_wr_en` pulse. After release, the next `start` yields the correct sum.
